ram_modport: RTL and testbench
==============================

// Module: ram_modport
// PURPOSE
//   Single-port synchronous RAM, 32 words x 8 bits, one shared address bus.
//   Separate write and read enables; registered read data.
//   Storage leaf for the RAM verification environment: the driver sources
//   data_in/address/enables, the monitor samples data_out.
//   All ports are sampled and updated on posedge clk.
// PARAMETERS
//   DATA_W   8    data word width (bits)
//   ADDR_W   5    address width; depth = 2**ADDR_W = 32 words
//   RST_VAL  0    value loaded into every memory word and data_out on reset
// PORTS
//   clk        in   1       single clock, all logic on rising edge
//   reset      in   1       synchronous, active-high reset
//   write_enb  in   1       write strobe: store data_in at address
//   read_enb   in   1       read strobe: fetch word at address into data_out
//   address    in   ADDR_W  word address, 0..31, shared by read and write
//   data_in    in   DATA_W  write data
//   data_out   out  DATA_W  registered read data
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset (reset=1 at posedge):
//   - data_out <= RST_VAL; all 32 words <= RST_VAL.
//   - write_enb/read_enb ignored that cycle; reset has top priority.
//   - Asserting reset mid-operation discards any access sampled in that cycle.
//   Write (reset=0, write_enb=1):
//   - mem[address] <= data_in at the posedge; data_out unchanged.
//   Read (reset=0, write_enb=0, read_enb=1):
//   - data_out <= mem[address] at the posedge: 1-cycle latency, visible
//     after the edge at which read_enb is sampled high.
//   Simultaneous write_enb=1 and read_enb=1:
//   - write wins; mem[address] <= data_in; data_out holds its previous value.
//   Idle (both enables 0):
//   - data_out holds its last value; memory unchanged.
//   Read of a word written in the immediately preceding cycle returns the
//   new data (write completes at the earlier edge).
//   Address is full-range; no out-of-range case; 0 and 31 both valid.
//   No handshake/ready; an access is accepted every cycle.
//   No X on data_out after the first reset.
// TESTING
//   1. reset=1 for 2 cycles, then read addr 0 and 31 -> data_out=8'h00 both.
//   2. write 8'hA5 @ addr 5; next cycle read addr 5 -> data_out=8'hA5 one
//      cycle after read_enb is sampled.
//   3. write 8'h3C @ 0 and 8'hC3 @ 31, read both back -> 8'h3C, 8'hC3
//      (address boundaries, no aliasing).
//   4. data_out=8'hA5; drive write_enb=read_enb=1, addr 5, data_in 8'h77
//      -> data_out stays 8'hA5; a later read of addr 5 -> 8'h77.
//   5. data_out=8'h77, enables low for 3 cycles -> data_out stays 8'h77.
//   6. write 8'hFF @ 10; assert reset with write_enb=1, data_in 8'h11
//      -> data_out=8'h00; read addr 10 after reset -> 8'h00.

Source files
------------

// File: rtl/ram_modport.sv
// ram_modport: single-port synchronous RAM, 2**ADDR_W words x DATA_W bits.
// One address bus is shared by reads and writes. Read data is registered.
// Ports:
//   clk        rising-edge clock for all logic
//   reset      synchronous, active-high; clears every word and data_out to RST_VAL
//   write_enb  store data_in at address (takes priority over read_enb)
//   read_enb   load mem[address] into data_out, visible after the sampling edge
//   address    word address, full range valid
//   data_in    write data
//   data_out   registered read data; holds its value when no read is performed
module ram_modport #(
  parameter int unsigned             DATA_W  = 8,
  parameter int unsigned             ADDR_W  = 5,
  parameter logic [DATA_W-1:0]       RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset has top priority and discards any access sampled in the same cycle.
  // A simultaneous write and read performs only the write; data_out holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= RST_VAL;
      end
      data_out <= RST_VAL;
    end else if (write_enb) begin
      mem[address] <= data_in;
    end else if (read_enb) begin
      data_out <= mem[address];
    end
  end

endmodule

// File: tb/tb_ram_modport.sv
// Self-checking bench for ram_modport: directed scenarios followed by random
// traffic, with expected data_out values queued at issue time and compared
// by an independent monitor one edge later.
module tb_ram_modport;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic [4:0] address = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;

  ram_modport #(.DATA_W(8), .ADDR_W(5), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain array plus the last value presented on data_out.
  logic [7:0] ref_mem [32];
  logic [7:0] ref_out;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  int compared   = 0;
  int mismatched = 0;

  // Apply one cycle of stimulus at the falling edge and queue the value
  // data_out must show after the following rising edge.
  task automatic cyc(input logic rst, input logic we, input logic re,
                     input logic [4:0] a, input logic [7:0] d, input string tag);
    @(negedge clk);
    reset     = rst;
    write_enb = we;
    read_enb  = re;
    address   = a;
    data_in   = d;
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
      ref_out = 8'h00;
    end else if (we) begin
      ref_mem[a] = d;
    end else if (re) begin
      ref_out = ref_mem[a];
    end
    exp_q.push_back(ref_out);
    tag_q.push_back(tag);
  endtask

  // Monitor: checks data_out shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        compared++;
        if (data_out !== e) begin
          mismatched++;
          $display("FAIL %s: data_out=%h expected %h", t, data_out, e);
        end
      end
    end
  end

  initial begin
    // 1. reset, then read both address boundaries
    cyc(1, 0, 0, 5'd0,  8'h00, "reset0");
    cyc(1, 0, 0, 5'd0,  8'h00, "reset1");
    cyc(0, 0, 1, 5'd0,  8'h00, "rd_after_rst_0");
    cyc(0, 0, 1, 5'd31, 8'h00, "rd_after_rst_31");
    // 2. write then immediate read-back
    cyc(0, 1, 0, 5'd5,  8'hA5, "wr5");
    cyc(0, 0, 1, 5'd5,  8'h00, "rd5");
    // 3. boundaries, no aliasing
    cyc(0, 1, 0, 5'd0,  8'h3C, "wr0");
    cyc(0, 1, 0, 5'd31, 8'hC3, "wr31");
    cyc(0, 0, 1, 5'd0,  8'h00, "rd0");
    cyc(0, 0, 1, 5'd31, 8'h00, "rd31");
    cyc(0, 0, 1, 5'd5,  8'h00, "rd5_again");
    // 4. simultaneous write and read: write wins, data_out holds
    cyc(0, 1, 1, 5'd5,  8'h77, "wr_rd_both");
    cyc(0, 0, 1, 5'd5,  8'h00, "rd5_new");
    // 5. idle holds
    cyc(0, 0, 0, 5'd3,  8'h12, "idle0");
    cyc(0, 0, 0, 5'd9,  8'h34, "idle1");
    cyc(0, 0, 0, 5'd31, 8'h56, "idle2");
    // 6. reset discards a concurrent write and clears memory
    cyc(0, 1, 0, 5'd10, 8'hFF, "wr10");
    cyc(0, 0, 1, 5'd10, 8'h00, "rd10_ff");
    cyc(1, 1, 0, 5'd10, 8'h11, "rst_with_wr");
    cyc(0, 0, 1, 5'd10, 8'h00, "rd10_cleared");
    cyc(0, 0, 1, 5'd5,  8'h00, "rd5_cleared");

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          8'($urandom_range(0, 255)), "random");
    end
    cyc(0, 0, 0, 5'd0, 8'h00, "final_idle");

    // Let the monitor drain; anything left unchecked is a failure.
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
